// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port memory between the CPU fetch and data ports
// Ports: inclk/rstn clock and async active-low reset; if_* fetch port (req/addr in, rdata/ready out);
// d_* data port (req/we/be/addr/wdata in, rdata/ready out); stall freezes the core while a request
// is pending; m_* memory side (cs/we/be/addr/wdata out, rdata in, combinational from m_addr).
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WAIT_STATES = 1,
  parameter int DATA_PRIORITY = 1,
  localparam int BE_W = DATA_W / 8
) (
  input  logic              inclk,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [BE_W-1:0]   d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              stall,
  output logic              m_cs,
  output logic              m_we,
  output logic [BE_W-1:0]   m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic last_q, last_d;
  logic gnt_q, gnt_d;
  logic we_q, we_d;
  logic [BE_W-1:0] be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic pick;
  logic busy;
  // 1 selects the data port; under round-robin the data port wins a tie only if the fetch port went last
  assign pick = d_req & (~if_req | (DATA_PRIORITY != 0) | ~last_q);
  assign busy = state_q == BUSY;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last_d = last_q;
    gnt_d = gnt_q;
    we_d = we_q;
    be_d = be_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: if (if_req | d_req) begin
        state_d = BUSY;
        cnt_d = 4'(WAIT_STATES);
        last_d = pick;
        gnt_d = pick;
        we_d = pick & d_we;
        be_d = pick ? d_be : '0;
        addr_d = pick ? d_addr : if_addr;
        wdata_d = pick ? d_wdata : '0;
      end
      BUSY: if (cnt_q != 0) cnt_d = cnt_q - 4'd1;
      else begin
        state_d = DONE;
        d_rdata_d = gnt_q ? m_rdata : d_rdata_q;
        if_rdata_d = gnt_q ? if_rdata_q : m_rdata;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge inclk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      last_q <= 1'b0;
      gnt_q <= 1'b0;
      we_q <= 1'b0;
      be_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      if_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      gnt_q <= gnt_d;
      we_q <= we_d;
      be_q <= be_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end
  // the write strobe is confined to the final BUSY cycle so each write lands exactly once
  assign m_cs = busy;
  assign m_we = busy & (cnt_q == 0) & we_q;
  assign m_be = busy ? be_q : '0;
  assign m_addr = busy ? addr_q : '0;
  assign m_wdata = busy ? wdata_q : '0;
  assign if_ready = (state_q == DONE) & ~gnt_q;
  assign d_ready = (state_q == DONE) & gnt_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata = d_rdata_q;
  assign stall = (if_req & ~if_ready) | (d_req & ~d_ready);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench over three arbiter configurations
module tb_mem_bus_arbiter;
  localparam int N = 3;
  logic inclk = 1'b0;
  always #5 inclk = ~inclk;
  logic rstn [N];
  logic if_req [N];
  logic d_req [N];
  logic d_we [N];
  logic if_ready [N];
  logic d_ready [N];
  logic stall [N];
  logic m_cs [N];
  logic m_we [N];
  logic pre_we [N];
  logic [31:0] if_addr [N];
  logic [31:0] d_addr [N];
  logic [31:0] d_wdata [N];
  logic [31:0] if_rdata [N];
  logic [31:0] d_rdata [N];
  logic [31:0] m_addr [N];
  logic [31:0] m_wdata [N];
  logic [31:0] m_rdata [N];
  logic [3:0] d_be [N];
  logic [3:0] m_be [N];
  logic [5:0] pre_a;
  logic [31:0] pre_d;
  for (genvar g = 0; g < N; g++) begin : gi
    logic [31:0] mem [64];
    int we_cnt = 0;
    mem_bus_arbiter #(
      .WAIT_STATES(g == 0 ? 1 : g == 1 ? 0 : 3),
      .DATA_PRIORITY(g == 1 ? 0 : 1)
    ) dut (
      .inclk(inclk), .rstn(rstn[g]),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_rdata(if_rdata[g]), .if_ready(if_ready[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_be(d_be[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_rdata(d_rdata[g]), .d_ready(d_ready[g]), .stall(stall[g]),
      .m_cs(m_cs[g]), .m_we(m_we[g]), .m_be(m_be[g]), .m_addr(m_addr[g]), .m_wdata(m_wdata[g]),
      .m_rdata(m_rdata[g])
    );
    assign m_rdata[g] = mem[m_addr[g][7:2]];
    always @(posedge inclk) begin
      if (pre_we[g]) mem[pre_a] <= pre_d;
      if (m_cs[g] && m_we[g]) begin
        for (int b = 0; b < 4; b++)
          if (m_be[g][b]) mem[m_addr[g][7:2]][8*b +: 8] <= m_wdata[g][8*b +: 8];
        we_cnt <= we_cnt + 1;
      end
    end
  end
  typedef struct {int g; bit p; logic [31:0] d; bit cd;} exp_t;
  exp_t sb [$];
  int checks = 0;
  int fails = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask
  task automatic push(input int g, input bit p, input logic [31:0] d, input bit cd);
    sb.push_back('{g, p, d, cd});
  endtask
  task automatic pop_chk(input int g, input bit p, input logic [31:0] d);
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL sb_unexpected inst=%0d port=%0d data=%h", g, p, d);
    end else begin
      exp_t e;
      e = sb.pop_front();
      if (e.g != g || e.p != p || (e.cd && e.d !== d)) begin
        fails++;
        $display("FAIL sb_resp got inst=%0d port=%0d data=%h exp inst=%0d port=%0d data=%h", g, p, d, e.g, e.p, e.d);
      end
    end
  endtask
  task automatic monitor();
    forever begin
      @(negedge inclk);
      for (int g = 0; g < N; g++) begin
        if (d_ready[g]) pop_chk(g, 1'b1, d_rdata[g]);
        if (if_ready[g]) pop_chk(g, 1'b0, if_rdata[g]);
      end
    end
  endtask
  task automatic preload(input int g, input logic [5:0] a, input logic [31:0] d);
    @(posedge inclk);
    #1 pre_we[g] = 1'b1;
    pre_a = a;
    pre_d = d;
    @(posedge inclk);
    #1 pre_we[g] = 1'b0;
  endtask
  task automatic wait_ready(input int g, input bit p, output int cyc, output int stl);
    cyc = -1;
    stl = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge inclk);
      if (p ? d_ready[g] : if_ready[g]) begin
        cyc = i;
        break;
      end
      stl += int'(stall[g]);
    end
  endtask
  initial begin
    int cyc, stl, n, w0;
    for (int g = 0; g < N; g++) begin
      rstn[g] = 1'b0; if_req[g] = 1'b0; d_req[g] = 1'b0; d_we[g] = 1'b0; pre_we[g] = 1'b0;
      if_addr[g] = '0; d_addr[g] = '0; d_wdata[g] = '0; d_be[g] = '0;
    end
    pre_a = '0;
    pre_d = '0;
    fork monitor(); join_none
    preload(0, 6'd4, 32'hDEADBEEF);
    preload(0, 6'd8, 32'hAAAAAAAA);
    preload(1, 6'd0, 32'h11111111);
    preload(1, 6'd1, 32'h22222222);
    preload(2, 6'd2, 32'h55555555);
    @(negedge inclk);
    for (int g = 0; g < N; g++) begin
      chk("rst_m_cs", 32'(m_cs[g]), 0);
      chk("rst_m_we", 32'(m_we[g]), 0);
      chk("rst_m_addr", m_addr[g], 0);
      chk("rst_ready", 32'(if_ready[g] | d_ready[g]), 0);
      chk("rst_rdata", if_rdata[g] | d_rdata[g], 0);
      chk("rst_stall", 32'(stall[g]), 0);
    end
    @(posedge inclk);
    #1 for (int g = 0; g < N; g++) rstn[g] = 1'b1;
    @(posedge inclk);
    #1 if_addr[0] = 32'h10; if_req[0] = 1'b1;
    push(0, 1'b0, 32'hDEADBEEF, 1'b1);
    wait_ready(0, 1'b0, cyc, stl);
    chk("t1_latency", cyc, 3);
    chk("t1_stall_cycles", stl, 3);
    @(posedge inclk);
    #1 if_req[0] = 1'b0;
    @(negedge inclk);
    chk("t1_rdata_hold", if_rdata[0], 32'hDEADBEEF);
    chk("t1_idle_cs", 32'(m_cs[0]), 0);
    w0 = gi[0].we_cnt;
    @(posedge inclk);
    #1 d_addr[0] = 32'h20; d_we[0] = 1'b1; d_be[0] = 4'b0011; d_wdata[0] = 32'h12345678; d_req[0] = 1'b1;
    push(0, 1'b1, 32'h0, 1'b0);
    @(posedge inclk);
    #1 d_addr[0] = 32'h10; d_wdata[0] = 32'hFFFFFFFF;
    wait_ready(0, 1'b1, cyc, stl);
    chk("t2_wr_latency", cyc, 2);
    @(posedge inclk);
    #1 d_req[0] = 1'b0; d_we[0] = 1'b0;
    chk("t2_we_strobes", gi[0].we_cnt - w0, 1);
    chk("t2_mem_merge", gi[0].mem[8], 32'hAAAA5678);
    chk("t2_latched_addr", gi[0].mem[4], 32'hDEADBEEF);
    @(posedge inclk);
    #1 d_addr[0] = 32'h20; d_req[0] = 1'b1;
    push(0, 1'b1, 32'hAAAA5678, 1'b1);
    wait_ready(0, 1'b1, cyc, stl);
    chk("t2_rd_latency", cyc, 3);
    @(posedge inclk);
    #1 d_req[0] = 1'b0;
    @(posedge inclk);
    #1 if_addr[0] = 32'h10; if_req[0] = 1'b1; d_addr[0] = 32'h20; d_req[0] = 1'b1;
    push(0, 1'b1, 32'hAAAA5678, 1'b1);
    push(0, 1'b0, 32'hDEADBEEF, 1'b1);
    wait_ready(0, 1'b1, cyc, stl);
    chk("t3_d_latency", cyc, 3);
    @(posedge inclk);
    #1 d_req[0] = 1'b0;
    @(negedge inclk);
    chk("t3_no_grant_in_done", 32'(m_cs[0]), 0);
    wait_ready(0, 1'b0, cyc, stl);
    chk("t3_if_latency", cyc, 2);
    @(posedge inclk);
    #1 if_req[0] = 1'b0;
    @(posedge inclk);
    #1 if_addr[1] = 32'h0; d_addr[1] = 32'h4; if_req[1] = 1'b1; d_req[1] = 1'b1;
    push(1, 1'b1, 32'h22222222, 1'b1);
    push(1, 1'b0, 32'h11111111, 1'b1);
    push(1, 1'b1, 32'h22222222, 1'b1);
    push(1, 1'b0, 32'h11111111, 1'b1);
    n = 0;
    cyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge inclk);
      if (if_ready[1] | d_ready[1]) n++;
      if (n == 4) begin
        cyc = i;
        break;
      end
    end
    chk("t4_completions", n, 4);
    chk("t4_total_cycles", cyc, 11);
    @(posedge inclk);
    #1 if_req[1] = 1'b0; d_req[1] = 1'b0;
    @(posedge inclk);
    #1 d_addr[1] = 32'h4; d_req[1] = 1'b1;
    push(1, 1'b1, 32'h22222222, 1'b1);
    @(posedge inclk);
    #1 d_req[1] = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge inclk);
      n += int'(d_ready[1]);
    end
    chk("t6_ready_pulses", n, 1);
    @(posedge inclk);
    #1 d_addr[1] = 32'h0; d_req[1] = 1'b1;
    push(1, 1'b1, 32'h11111111, 1'b1);
    wait_ready(1, 1'b1, cyc, stl);
    chk("t6_next_latency", cyc, 2);
    @(posedge inclk);
    #1 d_req[1] = 1'b0;
    w0 = gi[2].we_cnt;
    @(posedge inclk);
    #1 d_addr[2] = 32'h8; d_we[2] = 1'b1; d_be[2] = 4'hF; d_wdata[2] = 32'h99999999; d_req[2] = 1'b1;
    @(posedge inclk);
    @(posedge inclk);
    #1 rstn[2] = 1'b0; d_req[2] = 1'b0;
    #1 chk("t5_m_cs", 32'(m_cs[2]), 0);
    chk("t5_m_we", 32'(m_we[2]), 0);
    chk("t5_m_addr", m_addr[2], 0);
    chk("t5_m_wdata", m_wdata[2], 0);
    chk("t5_m_be", 32'(m_be[2]), 0);
    chk("t5_stall", 32'(stall[2]), 0);
    repeat (2) @(posedge inclk);
    #1 rstn[2] = 1'b1; d_we[2] = 1'b0;
    repeat (6) @(negedge inclk);
    chk("t5_no_strobe", gi[2].we_cnt - w0, 0);
    chk("t5_mem_intact", gi[2].mem[2], 32'h55555555);
    chk("t5_idle_cs", 32'(m_cs[2]), 0);
    @(posedge inclk);
    #1 d_addr[2] = 32'h8; d_req[2] = 1'b1;
    push(2, 1'b1, 32'h55555555, 1'b1);
    wait_ready(2, 1'b1, cyc, stl);
    chk("t5_post_reset_latency", cyc, 5);
    @(posedge inclk);
    #1 d_req[2] = 1'b0;
    repeat (3) @(negedge inclk);
    chk("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
